// File: rtl/mano_pkg.sv
// Shared constants, types and decode helpers for the Mano basic computer front end.
package mano_pkg;

  localparam int unsigned NUM_T   = 8;
  localparam int unsigned SC_W    = $clog2(NUM_T);
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OPC_MSB = 14;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned IND_BIT = WORD_W - 1;
  localparam int unsigned D_RREF  = 7;

  typedef logic [NUM_T-1:0] t_onehot;

  // One-hot decode of a timing index.
  function automatic t_onehot sc_onehot(input logic [SC_W-1:0] idx);
    t_onehot r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // One-hot decode of the 3-bit opcode field.
  function automatic logic [7:0] opc_decode(input logic [2:0] opc);
    logic [7:0] r;
    r      = '0;
    r[opc] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter: clear/increment with enable, gated one-hot timing decode,
// and a one-cycle overrun pulse when the count wraps without a clear.
module mano_seq_counter
  import mano_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            gate_i,
  output logic [SC_W-1:0] sc_o,
  output t_onehot         t_o,
  output logic            overrun_o
);

  logic [SC_W-1:0] sc_q, sc_d;
  logic            ovr_q, ovr_d;

  always_comb begin
    sc_d  = sc_q;
    ovr_d = 1'b0;
    if (en_i) begin
      if (clr_i) begin
        sc_d = '0;
      end else begin
        sc_d  = sc_q + SC_W'(1);
        ovr_d = (sc_q == SC_W'(NUM_T - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      ovr_q <= ovr_d;
    end
  end

  assign sc_o      = sc_q;
  assign overrun_o = ovr_q;
  assign t_o       = gate_i ? sc_onehot(sc_q) : '0;

endmodule

// File: rtl/mano_timing_decoder.sv
// Timing and decode front end: S flip-flop, IR, indirect flip-flop I, the
// opcode decoder, and the sequence counter that produces T[7:0].
module mano_timing_decoder
  import mano_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              sc_clr,
  input  logic [WORD_W-1:0] bus_in,
  output logic [NUM_T-1:0]  T,
  output logic [7:0]        D,
  output logic              J,
  output logic [WORD_W-1:0] ir_q,
  output logic [SC_W-1:0]   sc_q,
  output logic              running,
  output logic              sc_overrun
);

  logic              s_q, s_d;
  logic              i_q, i_d;
  logic [WORD_W-1:0] ir_d;
  logic [SC_W-1:0]   sc;
  t_onehot           t_vec;

  mano_seq_counter u_sc (
    .clk       (clk),
    .rst       (rst),
    .en_i      (s_q),
    .clr_i     (halt | sc_clr),
    .gate_i    (s_q),
    .sc_o      (sc),
    .t_o       (t_vec),
    .overrun_o (sc_overrun)
  );

  // IR loads at the end of T1 and I at the end of T2, regardless of sc_clr.
  always_comb begin
    s_d  = s_q;
    ir_d = ir_q;
    i_d  = i_q;
    if (halt) begin
      s_d = 1'b0;
    end else if (start) begin
      s_d = 1'b1;
    end
    if (s_q && (sc == SC_W'(1))) begin
      ir_d = bus_in;
    end
    if (s_q && (sc == SC_W'(2))) begin
      i_d = ir_q[IND_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= 1'b0;
      i_q  <= 1'b0;
      ir_q <= '0;
    end else begin
      s_q  <= s_d;
      i_q  <= i_d;
      ir_q <= ir_d;
    end
  end

  assign T       = t_vec;
  assign D       = opc_decode(ir_q[OPC_MSB:OPC_LSB]);
  assign J       = i_q;
  assign sc_q    = sc;
  assign running = s_q;

endmodule
